// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared definitions for the seven-segment scan decoder.
//   - Segment codes (a..g in bits 0..6, active-high), including the
//     alternate 6/7/9 glyphs some drivers emit.
//   - FSM state enum for the per-digit settle tracker.
//   - Digit slot indices (ones = 0 .. thousands = 3).
//   - Helpers: one-hot test, strobe-to-index, BCD-to-binary.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 4;

  localparam int DIG_ONES      = 0;
  localparam int DIG_TENS      = 1;
  localparam int DIG_HUNDREDS  = 2;
  localparam int DIG_THOUSANDS = 3;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_6_ALT = 7'h7C;
  localparam logic [6:0] SEG_7_ALT = 7'h27;
  localparam logic [6:0] SEG_9_ALT = 7'h67;

  typedef enum logic [1:0] {
    WAIT_SEL = 2'd0,
    SETTLE   = 2'd1,
    HOLD     = 2'd2
  } state_e;

  function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

  // Only meaningful for a one-hot vector.
  function automatic logic [1:0] sel_index(input logic [NUM_DIGITS-1:0] v);
    logic [1:0] idx;
    idx = 2'(DIG_ONES);
    if (v[DIG_TENS])      idx = 2'(DIG_TENS);
    if (v[DIG_HUNDREDS])  idx = 2'(DIG_HUNDREDS);
    if (v[DIG_THOUSANDS]) idx = 2'(DIG_THOUSANDS);
    return idx;
  endfunction

  function automatic logic [15:0] bcd_to_bin(input logic [NUM_DIGITS-1:0][3:0] d);
    return 16'(d[3]) * 16'd1000 + 16'(d[2]) * 16'd100 +
           16'(d[1]) * 16'd10   + 16'(d[0]);
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: combinational seven-segment pattern to decimal digit.
//   pattern[6:0] : segments a..g, active-high
//   digit[3:0]   : decoded value 0..9 (0 when invalid)
//   invalid      : pattern is not a recognised digit glyph (includes blank)
module seg7_to_bcd
  import seg_scan_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       invalid
);

  always_comb begin
    digit   = 4'd0;
    invalid = 1'b0;
    case (pattern)
      SEG_0:              digit = 4'd0;
      SEG_1:              digit = 4'd1;
      SEG_2:              digit = 4'd2;
      SEG_3:              digit = 4'd3;
      SEG_4:              digit = 4'd4;
      SEG_5:              digit = 4'd5;
      SEG_6, SEG_6_ALT:   digit = 4'd6;
      SEG_7, SEG_7_ALT:   digit = 4'd7;
      SEG_8:              digit = 4'd8;
      SEG_9, SEG_9_ALT:   digit = 4'd9;
      default:            invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: receive side of a multiplexed 4-digit 7-segment display.
// Synchronizes the digit strobes and segment bus, waits for each digit to be
// stable for STABLE_CYCLES samples, decodes it into its slot, and publishes
// the 4-digit number once every slot has been captured in one frame.
//
// Parameters
//   STABLE_CYCLES : identical synchronized samples needed to capture (1..255)
//   UUID          : instance identifier, carried only
// Ports
//   clk, rst      : clock; asynchronous active-low reset
//   sel1..sel4    : ones..thousands digit strobes, active-high
//   seg[7:0]      : segments a..g in [6:0]; dp in [7] is ignored
//   value[15:0]   : decoded number (packed BCD, or binary with SEG_SCAN_BIN_EN)
//   value_valid   : one-cycle pulse when value updates
//   frame_err     : one-cycle pulse when a frame is discarded (bad glyph)
//   digit_mask    : digits captured so far in the current frame, bit0 = ones
//
// Build option: define SEG_SCAN_BIN_EN to output binary (0..9999) with one
// extra pipeline stage on value/value_valid.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int UUID          = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel1,
  input  logic        sel2,
  input  logic        sel3,
  input  logic        sel4,
  input  logic [7:0]  seg,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        frame_err,
  output logic [3:0]  digit_mask
);
  import seg_scan_pkg::*;

  localparam int          unused_uuid = UUID;
  localparam logic [7:0]  CNT_LAST    = 8'(STABLE_CYCLES - 1);
`ifdef SEG_SCAN_BIN_EN
  localparam int          STAGES      = 1;
`else
  localparam int          STAGES      = 0;
`endif
  localparam int          PW          = STAGES + 1;

  // dp carries no digit information
  logic unused_dp;
  assign unused_dp = seg[7];

  // ---------------------------------------------------------------- sync
  logic [10:0] raw_in, sync1_q, sync2_q;
  logic [NUM_DIGITS-1:0] sel_s;
  logic [6:0]            pat_s;

  assign raw_in = {sel4, sel3, sel2, sel1, seg[6:0]};
  assign sel_s  = sync2_q[10:7];
  assign pat_s  = sync2_q[6:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------- FSM
  state_e                state_q, state_d;
  logic [NUM_DIGITS-1:0] lat_sel_q, lat_sel_d;
  logic [6:0]            lat_pat_q, lat_pat_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  cap, acq, onehot, match;

  assign onehot = is_onehot(sel_s);
  assign match  = (sel_s == lat_sel_q) && (pat_s == lat_pat_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= WAIT_SEL;
      lat_sel_q <= '0;
      lat_pat_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      lat_sel_q <= lat_sel_d;
      lat_pat_q <= lat_pat_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_sel_d = lat_sel_q;
    lat_pat_d = lat_pat_q;
    cnt_d     = cnt_q;
    cap       = 1'b0;
    acq       = 1'b0;
    case (state_q)
      WAIT_SEL: acq = 1'b1;
      SETTLE: begin
        if (!onehot)               state_d = WAIT_SEL;
        else if (!match)           acq = 1'b1;
        // Capturing on the cycle the count would reach STABLE_CYCLES keeps
        // the capture edge STABLE_CYCLES+1 clocks after the first sample.
        else if (cnt_q == CNT_LAST) begin
          cap     = 1'b1;
          state_d = HOLD;
        end else                   cnt_d = cnt_q + 8'd1;
      end
      HOLD:     acq = !match;
      default:  state_d = WAIT_SEL;
    endcase
    // Shared WAIT_SEL behaviour: HOLD and SETTLE fall into it on the same
    // cycle a change is seen, so a back-to-back digit loses no time.
    if (acq) begin
      if (onehot) begin
        lat_sel_d = sel_s;
        lat_pat_d = pat_s;
        cnt_d     = '0;
        state_d   = SETTLE;
      end else begin
        state_d   = WAIT_SEL;
      end
    end
  end

  // ---------------------------------------------------------------- capture
  logic [3:0]                  cap_digit;
  logic                        cap_invalid;
  logic [1:0]                  cap_idx;
  logic [NUM_DIGITS-1:0]       mask_q, mask_nx;
  logic [NUM_DIGITS-1:0][3:0]  slot_q, slots_nx;
  logic                        frame_err_q, emit;

  seg7_to_bcd u_dec (
    .pattern (lat_pat_q),
    .digit   (cap_digit),
    .invalid (cap_invalid)
  );

  assign cap_idx = sel_index(lat_sel_q);

  always_comb begin
    slots_nx          = slot_q;
    slots_nx[cap_idx] = cap_digit;
    mask_nx           = mask_q | lat_sel_q;
    emit              = cap && !cap_invalid && (mask_nx == '1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_q      <= '0;
      slot_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (cap) begin
        if (cap_invalid) begin
          mask_q      <= '0;
          slot_q      <= '0;
          frame_err_q <= 1'b1;
        end else begin
          slot_q <= slots_nx;
          // Frame done: start the next frame immediately, slots retained.
          mask_q <= emit ? '0 : mask_nx;
        end
      end
    end
  end

  // ---------------------------------------------------------------- output
  logic [STAGES:0] vld_pipe;
  logic [15:0]     value_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_pipe <= '0;
    else      vld_pipe <= PW'({vld_pipe, emit});
  end

`ifdef SEG_SCAN_BIN_EN
  logic [NUM_DIGITS-1:0][3:0] bcd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd_q   <= '0;
      value_q <= '0;
    end else begin
      if (emit)        bcd_q   <= slots_nx;
      if (vld_pipe[0]) value_q <= bcd_to_bin(bcd_q);
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      value_q <= '0;
    else if (emit) value_q <= slots_nx;
  end
`endif

  assign value       = value_q;
  assign value_valid = vld_pipe[STAGES];
  assign frame_err   = frame_err_q;
  assign digit_mask  = mask_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;
  import seg_scan_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel1 = 1'b0, sel2 = 1'b0, sel3 = 1'b0, sel4 = 1'b0;
  logic [7:0]  seg = 8'h00;
  logic [15:0] value;
  logic        value_valid, frame_err;
  logic [3:0]  digit_mask;

  int n_assert = 0;
  int n_fail   = 0;
  int vv_cnt   = 0;
  int fe_cnt   = 0;
  logic [15:0] exp_q[$];

  seg_scan_decoder #(.STABLE_CYCLES(4), .UUID(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .sel1        (sel1),
    .sel2        (sel2),
    .sel3        (sel3),
    .sel4        (sel4),
    .seg         (seg),
    .value       (value),
    .value_valid (value_valid),
    .frame_err   (frame_err),
    .digit_mask  (digit_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] expv(input int d4, input int d3, input int d2, input int d1);
`ifdef SEG_SCAN_BIN_EN
    return 16'(d4 * 1000 + d3 * 100 + d2 * 10 + d1);
`else
    return {4'(d4), 4'(d3), 4'(d2), 4'(d1)};
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] s, input logic [7:0] p, input int n);
    {sel4, sel3, sel2, sel1} = s;
    seg = p;
    repeat (n) step();
  endtask

  // Scoreboard side: every value_valid pops one expected word.
  always @(negedge clk) begin
    if (rst) begin
      if (value_valid || frame_err)
        chk("vv_fe_exclusive", 16'(value_valid & frame_err), 16'd0);
      if (frame_err) fe_cnt++;
      if (value_valid) begin
        vv_cnt++;
        chk("vv_expected", 16'(exp_q.size() != 0), 16'd1);
        if (exp_q.size() != 0) chk("value", value, exp_q.pop_front());
      end
    end
  end

  initial begin
    // reset state
    repeat (3) step();
    chk("rst_value", value, 16'd0);
    chk("rst_vv", 16'(value_valid), 16'd0);
    chk("rst_fe", 16'(frame_err), 16'd0);
    chk("rst_mask", 16'(digit_mask), 16'd0);
    rst = 1'b1;
    repeat (2) step();

    // single frame 4123 with capture latency check on ones (dp set, ignored)
    exp_q.push_back(expv(4, 1, 2, 3));
    drive(4'b0001, 8'hCF, 6);
    chk("lat_before", 16'(digit_mask), 16'd0);
    step();
    chk("lat_capture", 16'(digit_mask), 16'd1);
    repeat (2) step();
    drive(4'b0010, 8'h5B, 10);
    drive(4'b0100, 8'h06, 10);
    drive(4'b1000, 8'h66, 10);
    drive(4'b0000, 8'h00, 5);
    chk("f1_vv_cnt", 16'(vv_cnt), 16'd1);
    chk("f1_mask", 16'(digit_mask), 16'd0);

    // 2-cycle glitch on ones delays capture by 4 clocks, then 3-cycle tens dwell
    drive(4'b0001, 8'h06, 2);
    drive(4'b0001, 8'h07, 2);
    seg = 8'h06;
    repeat (6) step();
    chk("glitch_before", 16'(digit_mask), 16'd0);
    step();
    chk("glitch_capture", 16'(digit_mask), 16'd1);
    repeat (3) step();
    drive(4'b0010, 8'h5B, 3);
    drive(4'b0100, 8'h06, 10);
    drive(4'b1000, 8'h66, 10);
    chk("short_dwell_mask", 16'(digit_mask), 16'b1101);
    chk("short_dwell_vv", 16'(vv_cnt), 16'd1);

    // blank pattern held on hundreds discards the frame
    drive(4'b0100, 8'h00, 10);
    chk("inv_fe_cnt", 16'(fe_cnt), 16'd1);
    chk("inv_mask", 16'(digit_mask), 16'd0);
    chk("inv_vv", 16'(vv_cnt), 16'd1);
    exp_q.push_back(expv(0, 6, 5, 8));
    drive(4'b0001, 8'h7F, 10);
    drive(4'b0010, 8'h6D, 10);
    drive(4'b0100, 8'h7D, 10);
    drive(4'b1000, 8'h3F, 10);
    drive(4'b0000, 8'h00, 5);
    chk("clean_vv_cnt", 16'(vv_cnt), 16'd2);

    // multi-hot strobe: nothing happens
    drive(4'b0011, 8'h06, 20);
    chk("mh_state", 16'(dut.state_q), 16'(WAIT_SEL));
    chk("mh_mask", 16'(digit_mask), 16'd0);
    chk("mh_vv", 16'(vv_cnt), 16'd2);
    chk("mh_fe", 16'(fe_cnt), 16'd1);

    // reset mid-frame with three digits captured
    drive(4'b0000, 8'h00, 3);
    drive(4'b0001, 8'h6F, 10);
    drive(4'b0010, 8'h67, 10);
    drive(4'b0100, 8'h6F, 10);
    chk("pre_rst_mask", 16'(digit_mask), 16'b0111);
    rst = 1'b0;
    #2;
    chk("mid_rst_value", value, 16'd0);
    chk("mid_rst_vv", 16'(value_valid), 16'd0);
    chk("mid_rst_fe", 16'(frame_err), 16'd0);
    chk("mid_rst_mask", 16'(digit_mask), 16'd0);
    {sel4, sel3, sel2, sel1} = 4'b0000;
    seg = 8'h00;
    repeat (3) step();
    rst = 1'b1;
    step();
    exp_q.push_back(expv(9, 9, 9, 9));
    drive(4'b0001, 8'h6F, 10);
    drive(4'b0010, 8'h67, 10);
    drive(4'b0100, 8'h6F, 10);
    drive(4'b1000, 8'h6F, 10);
    drive(4'b0000, 8'h00, 5);
    chk("r9_vv_cnt", 16'(vv_cnt), 16'd3);
    chk("r9_fe_cnt", 16'(fe_cnt), 16'd1);

    // ones overwritten 1 -> 7 -> 7(alt); alternate 6 and 9 glyphs
    drive(4'b0001, 8'h06, 10);
    drive(4'b0001, 8'h07, 10);
    drive(4'b0001, 8'h27, 10);
    chk("ovw_mask", 16'(digit_mask), 16'd1);
    exp_q.push_back(expv(0, 9, 6, 7));
    drive(4'b0010, 8'h7C, 10);
    drive(4'b0100, 8'h67, 10);
    drive(4'b1000, 8'h3F, 10);
    drive(4'b0000, 8'h00, 6);
    chk("alt_vv_cnt", 16'(vv_cnt), 16'd4);
    chk("alt_fe_cnt", 16'(fe_cnt), 16'd1);
    chk("sb_drained", 16'(exp_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive side of the multiplexed four-digit seven-segment display interface. Samples the `sel1..sel4` digit strobes and the `seg` bus, and recovers each digit from its segment pattern once the pattern has settled. When all four digits have been captured, it presents the displayed number as one word. Sits in the FPGA test fabric as a loopback checker behind the display-counter block, or behind any driver using the same scan order and segment encoding.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical synchronized samples required before a digit is captured; legal range 1..255.
- `UUID`, default 0: instance identifier, carried only.
- `clk` input 1: sole clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `sel1` input 1: ones-digit strobe, active-high.
- `sel2` input 1: tens-digit strobe.
- `sel3` input 1: hundreds-digit strobe.
- `sel4` input 1: thousands-digit strobe.
- `seg` input 8: segment bus. Bits 0..6 = segments a..g, active-high. Bit 7 = dp, ignored.
- `value` output 16: decoded number; format set by Configuration.
- `value_valid` output 1: one-cycle pulse when `value` updates.
- `frame_err` output 1: one-cycle pulse when a frame is discarded.
- `digit_mask` output 4: digits captured in the current frame; bit0 = ones.

## Operation
- **Input synchronization:** `sel1..4` and `seg[6:0]` pass through a 2-flop synchronizer before any use.
- **Strobe qualification:** the strobe vector is valid only when exactly one bit is set. All-zero or multi-hot returns the FSM to WAIT_SEL with no capture and no error (break-before-make gaps).
- **Segment decode:**
  - a..g pattern to digit: 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D or 0x7C→6, 0x07 or 0x27→7, 0x7F→8, 0x6F or 0x67→9.
  - Any other pattern, including 0x00, is invalid.
- **FSM states:**
  - WAIT_SEL: when the strobe is one-hot, latch strobe and pattern, clear the stability counter, go to SETTLE.
  - SETTLE: while strobe and pattern equal the latched values, increment the counter. A mismatch with a one-hot strobe relatches and restarts SETTLE; a non-one-hot strobe goes to WAIT_SEL. When the counter reaches `STABLE_CYCLES`, capture the digit and go to HOLD.
  - HOLD: stay until the strobe or pattern differs from the latch, then act as WAIT_SEL on that same cycle.
- **Capture, valid pattern:**
  - Store the digit in its slot and set its mask bit.
  - Re-capturing an already-set slot overwrites the slot; the mask is unchanged.
- **Capture, invalid pattern:** clear the mask and all slots, and pulse `frame_err`.
- **Frame completion:**
  - When a capture makes the mask 4'b1111, emit `value`, pulse `value_valid`, and clear the mask to 0 on the same edge.
  - Slots keep their contents.

## Timing
- **Reset values:** `value` = 0, `value_valid` = 0, `frame_err` = 0, `digit_mask` = 0. FSM = WAIT_SEL, synchronizers and slots = 0.
- **Capture latency:** the capture edge occurs `STABLE_CYCLES` + 1 clocks after the first synchronized sample of a stable digit. Raw-pin latency is 2 cycles more.
- **Output latency:**
  - `value_valid` and `frame_err` assert in the cycle after the capture edge.
  - With `SEG_SCAN_BIN_EN`, `value_valid` comes one further cycle later.
  - `value_valid` and `frame_err` are never asserted together.
- **Short dwell:** a digit held for fewer than `STABLE_CYCLES` + 1 synchronized cycles is never captured.
- **Reset mid-frame:** an asserted `rst` discards any partial frame and any in-flight conversion, with no pulse.

## Configuration
- **`SEG_SCAN_BIN_EN` defined:**
  - `value` = d4·1000 + d3·100 + d2·10 + d1, unsigned binary, range 0..9999, upper bits 0.
  - One pipeline register is added for the multiply-accumulate, so `value_valid` comes +1 cycle later.
- **`SEG_SCAN_BIN_EN` undefined:** `value` = packed BCD {d4, d3, d2, d1}, with no extra stage.

## Structure
- **Shared package `seg_scan_pkg`:**
  - Segment code constants SEG_0..SEG_9 plus the alternate codes.
  - FSM state enum (WAIT_SEL, SETTLE, HOLD).
  - Digit index constants.
- **Sub-module `seg7_to_bcd`:** combinational; pattern[6:0] → digit[3:0] plus an invalid flag. Shared with future display-checking blocks.

## Test plan
- **Single frame:** `STABLE_CYCLES` = 4; scan ones 0x4F, tens 0x5B, hundreds 0x06, thousands 0x66, each held 10 cycles. Required: one `value_valid`; `value` = 0x4123 (BCD) or 4123 (BIN).
- **Glitch and short dwell:** a 3-cycle tens dwell inside a frame → no capture of tens and no `value_valid`. A 2-cycle `seg` glitch during dwell → SETTLE restarts and capture is delayed by exactly the glitch recovery.
- **Invalid pattern:** `seg` = 0x00 held stable on hundreds → `frame_err` pulse; `digit_mask` = 0. The next clean 4-digit scan yields the correct `value`.
- **Multi-hot strobe:** `sel1` and `sel2` high together for 20 cycles → no capture and no error; FSM in WAIT_SEL.
- **Reset mid-frame:** reset with `digit_mask` = 4'b0111 → all outputs 0 in the reset cycle. The post-reset frame 9,9,9,9 → `value` = 0x9999 or 9999.
- **Alternate codes and overwrite:** ones re-scanned as 0x27 after 0x07, then remaining digits 0x7C, 0x67, 0x3F → `value` = 0x0967 or 967.
